// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine controller.
// Money values are in 5-cent units.
package vm_pkg;

    localparam int SUM_W = 3;

    localparam logic [3:0] NICKEL_VAL  = 4'd1;
    localparam logic [3:0] DIME_VAL    = 4'd2;
    localparam logic [3:0] QUARTER_VAL = 4'd5;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3,
        REFUND  = 3'd4
    } vm_state_t;

endpackage

// File: rtl/vm_dispense_timer.sv
// Loadable down-counter that times the dispense pulse.
// o_last marks the final active cycle so the controller can leave VEND on time.
module vm_dispense_timer #(
    parameter int DISP_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_active,
    output logic o_last
);

    localparam int CNT_W = $clog2(DISP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(DISP_CYCLES);

    logic [CNT_W-1:0] cnt_r;

    // Counter: load on start, count down to zero, then hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r <= '0;
        end else if (i_start) begin
            cnt_r <= LOAD_V;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_active = (cnt_r != '0);
    assign o_last   = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/vm_controller.sv
// Vending-machine sequencing FSM: coin decode, sum_register loading,
// dispense timing and change/refund handshake. VM_QUARTER_EN enables the quarter input.
module vm_controller
    import vm_pkg::*;
#(
    parameter int PRICE       = 3,
    parameter int DISP_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_nickel,
    input  logic             i_dime,
    input  logic             i_quarter,
    input  logic             i_cancel,
    input  logic             i_change_ack,
    input  logic [SUM_W-1:0] i_sum,
    output logic             o_sum_ld,
    output logic [SUM_W-1:0] o_sum_next,
    output logic             o_dispense,
    output logic [SUM_W-1:0] o_change,
    output logic             o_change_vld,
    output logic             o_coin_reject,
    output logic             o_busy
);

    localparam logic [SUM_W-1:0] PRICE_V = SUM_W'(PRICE);

    vm_state_t  state_r;
    vm_state_t  state_s;
    logic       coin_rej_s;
    logic       coin_rej_r;
    logic       timer_start_s;
    logic       timer_active_s;
    logic       timer_last_s;
    logic [1:0] coin_cnt_s;
    logic [3:0] coin_val_s;
    logic [3:0] coin_sum_s;
    logic       any_coin_s;
    logic       quarter_s;

`ifdef VM_QUARTER_EN
    assign quarter_s = i_quarter;
`else
    logic unused_quarter_s;
    assign unused_quarter_s = i_quarter;
    assign quarter_s        = 1'b0;
`endif

    // Coin decode: pulse count and the value of the single coin when exactly one is present.
    always_comb begin
        coin_cnt_s = {1'b0, i_nickel} + {1'b0, i_dime} + {1'b0, quarter_s};
        coin_val_s = (i_nickel  ? NICKEL_VAL  : 4'd0)
                   | (i_dime    ? DIME_VAL    : 4'd0)
                   | (quarter_s ? QUARTER_VAL : 4'd0);
        coin_sum_s = {1'b0, i_sum} + coin_val_s;
        any_coin_s = (coin_cnt_s != 2'd0);
    end

    // Next-state and Moore/Mealy outputs; coins outside COLLECT are refused by default.
    always_comb begin
        state_s       = state_r;
        o_sum_ld      = 1'b0;
        o_sum_next    = 3'd0;
        o_dispense    = 1'b0;
        o_change      = 3'd0;
        o_change_vld  = 1'b0;
        coin_rej_s    = any_coin_s;
        timer_start_s = 1'b0;
        case (state_r)
            CLEAR: begin
                o_sum_ld   = 1'b1;
                o_sum_next = 3'd0;
                state_s    = COLLECT;
            end
            COLLECT: begin
                if (i_sum >= PRICE_V) begin
                    state_s       = VEND;
                    timer_start_s = 1'b1;
                end else if (i_cancel && (i_sum != 3'd0)) begin
                    state_s = REFUND;
                end else if (coin_cnt_s == 2'd1) begin
                    if (coin_sum_s <= 4'd7) begin
                        o_sum_ld   = 1'b1;
                        o_sum_next = coin_sum_s[2:0];
                        coin_rej_s = 1'b0;
                    end else begin
                        coin_rej_s = 1'b1;
                    end
                end else begin
                    coin_rej_s = any_coin_s;
                end
            end
            VEND: begin
                o_dispense = timer_active_s;
                // A stalled timer must never trap the FSM in VEND.
                if (timer_last_s || !timer_active_s) begin
                    if (i_sum > PRICE_V) begin
                        state_s = CHANGE;
                    end else begin
                        state_s = CLEAR;
                    end
                end else begin
                    state_s = VEND;
                end
            end
            CHANGE: begin
                o_change     = i_sum - PRICE_V;
                o_change_vld = 1'b1;
                if (i_change_ack) begin
                    state_s = CLEAR;
                end else begin
                    state_s = CHANGE;
                end
            end
            REFUND: begin
                o_change     = i_sum;
                o_change_vld = 1'b1;
                if (i_change_ack) begin
                    state_s = CLEAR;
                end else begin
                    state_s = REFUND;
                end
            end
            default: begin
                state_s = CLEAR;
            end
        endcase
    end

    // State and reject-pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= CLEAR;
            coin_rej_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            coin_rej_r <= coin_rej_s;
        end
    end

    assign o_coin_reject = coin_rej_r;
    assign o_busy        = (state_r != COLLECT);

    vm_dispense_timer #(
        .DISP_CYCLES (DISP_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (timer_start_s),
        .o_active (timer_active_s),
        .o_last   (timer_last_s)
    );

endmodule

// File: tb/tb_vm_controller.sv
// Table-driven bench for vm_controller (PRICE=3) plus a PRICE=7 instance for overflow.
module tb_vm_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tie0 = 1'b0;

    logic nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0, ack = 1'b0;
    logic       sum_ld, dispense, change_vld, coin_reject, busy;
    logic [2:0] sum_next, change;
    logic [2:0] sum_q = 3'd0;

    logic n7 = 1'b0, d7 = 1'b0, c7 = 1'b0;
    logic       ld7, disp7, vld7, rej7, busy7;
    logic [2:0] nx7, chg7;
    logic [2:0] sum7_q = 3'd0;

    int total = 0;
    int passed = 0;

    localparam logic [4:0] I_0 = 5'b00000;
    localparam logic [4:0] I_N = 5'b10000;
    localparam logic [4:0] I_D = 5'b01000;
    localparam logic [4:0] I_Q = 5'b00100;
    localparam logic [4:0] I_C = 5'b00010;
    localparam logic [4:0] I_A = 5'b00001;

    typedef struct packed {
        logic [4:0]  in_v;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    vm_controller #(.PRICE(3), .DISP_CYCLES(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_nickel(nickel), .i_dime(dime), .i_quarter(quarter),
        .i_cancel(cancel), .i_change_ack(ack), .i_sum(sum_q),
        .o_sum_ld(sum_ld), .o_sum_next(sum_next), .o_dispense(dispense), .o_change(change),
        .o_change_vld(change_vld), .o_coin_reject(coin_reject), .o_busy(busy)
    );

    vm_controller #(.PRICE(7), .DISP_CYCLES(4)) u_dut7 (
        .i_clk(clk), .i_rst(rst), .i_nickel(n7), .i_dime(d7), .i_quarter(tie0),
        .i_cancel(c7), .i_change_ack(tie0), .i_sum(sum7_q),
        .o_sum_ld(ld7), .o_sum_next(nx7), .o_dispense(disp7), .o_change(chg7),
        .o_change_vld(vld7), .o_coin_reject(rej7), .o_busy(busy7)
    );

    // sum_register models
    always_ff @(posedge clk) begin
        if (sum_ld) sum_q <= sum_next;
        if (ld7) sum7_q <= nx7;
    end

    function automatic vec_t mk(input logic [4:0] in_v, input logic ld, input logic [2:0] nxt,
                                input logic disp, input logic [2:0] chg, input logic vld,
                                input logic rej, input logic bsy, input logic [2:0] sum);
        vec_t v;
        v.in_v = in_v;
        v.exp  = {ld, nxt, disp, chg, vld, rej, bsy, sum};
        return v;
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic [4:0] v);
        {nickel, dime, quarter, cancel, ack} = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset, nickel+dime to price, exact dispense
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_N, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_D, 1, 3, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 3));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 0, 1, 3));
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
        // dime, dime -> change 1 with delayed ack (ack during VEND ignored)
        vecs.push_back(mk(I_D, 1, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_D, 1, 4, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 0, 1, 4));
        vecs.push_back(mk(I_A, 0, 0, 1, 0, 0, 0, 1, 4));
        vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 0, 1, 4));
        vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 0, 1, 4));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(I_0, 0, 0, 0, 1, 1, 0, 1, 4));
        vecs.push_back(mk(I_A, 0, 0, 0, 1, 1, 0, 1, 4));
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 4));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
        // refund, cancel at zero, cancel+dime
        vecs.push_back(mk(I_N, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_C, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(I_A, 0, 0, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(I_C, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_D, 1, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_C | I_D, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(I_A, 0, 0, 0, 2, 1, 1, 1, 2));
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
        // simultaneous coins, coin at price, coin during VEND
        vecs.push_back(mk(I_N | I_D, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(I_D, 1, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_N, 1, 3, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(I_N, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(I_D, 0, 0, 1, 0, 0, 1, 1, 3));
        vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 1, 1, 3));
        vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 0, 1, 3));
        vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 0, 1, 3));
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef VM_QUARTER_EN
        vecs.push_back(mk(I_Q, 1, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 5));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(I_0, 0, 0, 1, 0, 0, 0, 1, 5));
        vecs.push_back(mk(I_A, 0, 0, 0, 2, 1, 0, 1, 5));
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
        vecs.push_back(mk(I_Q, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_N | I_Q, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(I_C, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(I_A, 0, 0, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(I_0, 1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(I_0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in_v);
            #1;
            check($sformatf("row%0d", i),
                  {sum_ld, sum_next, dispense, change, change_vld, coin_reject, busy, sum_q},
                  vecs[i].exp);
            @(negedge clk);
        end

        // reset in the middle of a vend
        drive(I_D); @(negedge clk);
        drive(I_D); @(negedge clk);
        drive(I_0); @(negedge clk);
        #1;
        check("vend_before_rst", {13'd0, dispense}, 14'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_clear",
              {3'd0, sum_ld, sum_next, dispense, change, change_vld, coin_reject, busy},
              {3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        #1;
        check("rst_mid_sum", {10'd0, busy, sum_q}, 14'd0);

        // PRICE=7 overflow: dime at sum 6 refused, sum holds
        d7 = 1'b1; @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("p7_sum6", {11'd0, sum7_q}, 14'd6);
        check("ovf_noload", {13'd0, ld7}, 14'd0);
        @(negedge clk);
        d7 = 1'b0;
        #1;
        check("ovf_reject", {10'd0, rej7, sum7_q}, {10'd0, 1'b1, 3'd6});
        @(negedge clk);
        #1;
        check("ovf_hold", {9'd0, busy7, rej7, sum7_q}, {9'd0, 1'b0, 1'b0, 3'd6});
        n7 = 1'b1;
        #1;
        check("p7_fill", {10'd0, ld7, nx7}, {10'd0, 1'b1, 3'd7});
        @(negedge clk);
        n7 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vm_controller.md
# vm_controller

Sequencing FSM for the vending-machine datapath: it decodes coin pulses, drives the load port of the 3-bit `sum_register`, and detects when the price is reached. It then times the dispense pulse and returns change or refunds through a valid/ack handshake. It sits between the coin-acceptor inputs and the `sum_register`, which is instantiated beside it at the vending-machine top level, and is the only writer of that register. All money values are in units of 5 cents.

## Interface
- `PRICE`, default 3, item price in 5¢ units; legal range 1..7.
- `DISP_CYCLES`, default 4, number of cycles `o_dispense` is held high; minimum 1.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_nickel` in 1: one-cycle coin pulse, value 1.
- `i_dime` in 1: one-cycle coin pulse, value 2.
- `i_quarter` in 1: one-cycle coin pulse, value 5 (used only with `VM_QUARTER_EN`).
- `i_cancel` in 1: refund request pulse.
- `i_change_ack` in 1: change/refund has been taken.
- `i_sum` in 3: current `sum_register` output.
- `o_sum_ld` out 1: load strobe to `sum_register`.
- `o_sum_next` out 3: value loaded into `sum_register`.
- `o_dispense` out 1: dispense actuator drive.
- `o_change` out 3: change/refund amount.
- `o_change_vld` out 1: `o_change` is valid.
- `o_coin_reject` out 1: registered one-cycle pulse when a coin is refused.
- `o_busy` out 1: high whenever the state is not COLLECT.

## Operation
- States: CLEAR, COLLECT, VEND, CHANGE, REFUND. `i_rst` forces CLEAR.
- **CLEAR**
  - Outputs: `o_sum_ld`=1, `o_sum_next`=0.
  - Next state: COLLECT unconditionally.
- **COLLECT, sum reached** (`i_sum` >= `PRICE`):
  - Go to VEND.
  - Any coin this cycle is rejected.
- **COLLECT, cancel** (`i_cancel` asserted):
  - If `i_sum`>0, go to REFUND.
  - If `i_sum`=0, ignore the cancel.
  - Cancel wins over a simultaneous coin, and that coin is rejected.
- **COLLECT, coin** (`i_sum` < `PRICE`, no cancel):
  - Accept only when exactly one coin pulse is high.
  - 4-bit sum `s` = `i_sum` + coin value.
  - If `s` <= 7: `o_sum_ld`=1 and `o_sum_next`=`s[2:0]`.
  - If `s` > 7: reject; no load.
  - Two or more simultaneous pulses: reject; no load.
- **Rejection**: `o_coin_reject` pulses in the next cycle. Coins arriving in any state other than COLLECT are also rejected.
- **VEND**
  - `o_dispense`=1 for exactly `DISP_CYCLES` cycles, timed by a down-counter.
  - On expiry: go to CHANGE if `i_sum` > `PRICE`, otherwise go to CLEAR.
- **CHANGE**
  - `o_change` = `i_sum` − `PRICE`; `o_change_vld`=1.
  - Both are held until `i_change_ack`; then go to CLEAR.
- **REFUND**
  - Same handshake as CHANGE, with `o_change` = `i_sum`.
- **Handshake rules**
  - An ack in the same cycle `o_change_vld` first rises is honoured.
  - An ack outside CHANGE/REFUND is ignored.
- **Output types**: `o_sum_ld`, `o_sum_next`, `o_dispense`, `o_change`, `o_change_vld` and `o_busy` are combinational from state, counter and `i_sum`.

## Timing
- Reset values, for the cycle after `i_rst`:
  - State is CLEAR.
  - `o_sum_ld`=1, `o_sum_next`=0, `o_busy`=1.
  - `o_dispense`, `o_change`, `o_change_vld` and `o_coin_reject` are all 0.
- Coin sequence:
  - Coin at cycle N: load strobe at N; `i_sum` updated at N+1.
  - If the price is reached, state is VEND at N+2 and `o_dispense` is high from N+2 through N+1+`DISP_CYCLES`.
- Dispense with no change: CLEAR follows the last dispense cycle, then COLLECT one cycle later.
- Reset mid-operation (any state): the next cycle is CLEAR. Dispense, change and reject outputs drop immediately and the sum is zeroed.
- Overflow example: a dime at sum 6 with `PRICE`=7 is rejected and the sum stays 6.

## Configuration
- Macro: `VM_QUARTER_EN`.
- Defined:
  - `i_quarter` is decoded as value 5.
  - It participates in the exactly-one-coin check.
- Undefined:
  - `i_quarter` is ignored entirely: no load, no reject, and it is not counted in the simultaneous-coin check.
  - The port remains present.

## Structure
- Package `vm_pkg`:
  - `SUM_W`=3.
  - Coin values `NICKEL_VAL`=1, `DIME_VAL`=2, `QUARTER_VAL`=5.
  - State enum `vm_state_t`.
- Sub-module `vm_dispense_timer`:
  - Loadable down-counter of width `$clog2(DISP_CYCLES+1)`.
  - Start input, active output.
- `sum_register` is not instantiated inside this block.

## Test plan
1. Reset: assert `i_rst` 2 cycles → `o_sum_ld`=1, `o_sum_next`=0 in the first post-reset cycle, then COLLECT with `o_busy`=0 and all other outputs 0.
2. `PRICE`=3: nickel, then dime → sum 1 then 3; `o_dispense` high exactly 4 cycles; no `o_change_vld`; sum cleared to 0.
3. Dime, dime → sum 4 → dispense → `o_change`=1 with `o_change_vld` held while `i_change_ack` is delayed 3 cycles → CLEAR after ack.
4. Nickel then cancel → `o_change`=1 refund and sum cleared. Cancel at sum 0 → no state change. Cancel and dime in the same cycle → refund of the prior sum plus a reject pulse.
5. Nickel and dime in the same cycle → `o_coin_reject` pulse, sum unchanged. Dime during VEND → reject. `PRICE`=7 at sum 6 plus dime → reject, sum stays 6.
6. With `VM_QUARTER_EN`: quarter at sum 0 → sum 5 → dispense → change 2. Without it: quarter pulse → no load and no reject.
